// File: rtl/wb_arbiter_m1.sv
// Round-robin writeback arbiter: N_SRC 2-deep FIFOs share one registered regfile write port.
// Handshake to wb_en takes 2 enabled cycles; src_ready is FIFO-not-full from registered state only.
module wb_arbiter_m1 #(
  parameter int N_SRC  = 3,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     async_rst,
  input  logic                     clk_en,
  input  logic [N_SRC-1:0]         src_valid,
  input  logic [N_SRC*ADDR_W-1:0]  src_addr,
  input  logic [N_SRC*DATA_W-1:0]  src_data,
  output logic [N_SRC-1:0]         src_ready,
  output logic                     wb_en,
  output logic [ADDR_W-1:0]        wb_addr,
  output logic [DATA_W-1:0]        wb_data,
  output logic [$clog2(N_SRC)-1:0] wb_src,
  output logic                     idle
);
  localparam int               SRC_W = $clog2(N_SRC);
  localparam logic [SRC_W:0]   N_EXT = (SRC_W+1)'(N_SRC);
  localparam logic [SRC_W-1:0] LAST  = SRC_W'(N_SRC-1);

  logic [1:0]        count  [N_SRC];
  logic [ADDR_W-1:0] addr_q [N_SRC][2];
  logic [DATA_W-1:0] data_q [N_SRC][2];
  logic [SRC_W-1:0]  rr_ptr;
  logic [SRC_W-1:0]  winner;
  logic              found;
  logic [SRC_W:0]    idx;
  logic [N_SRC-1:0]  push_v;
  logic [N_SRC-1:0]  pop_v;

  always_comb begin
    src_ready = '0;
    idle      = !wb_en;
    for (int i = 0; i < N_SRC; i++) begin
      src_ready[i] = (count[i] != 2'd2);
      if (count[i] != 2'd0) idle = 1'b0;
    end
  end

  // Scan from rr_ptr with wrap; first non-empty FIFO wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (idx >= N_EXT) idx = idx - N_EXT;
      if (!found && count[idx[SRC_W-1:0]] != 2'd0) begin
        found  = 1'b1;
        winner = idx[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    push_v = '0;
    pop_v  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      push_v[i] = src_valid[i] && src_ready[i];
      pop_v[i]  = found && (winner == SRC_W'(i));
    end
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      rr_ptr  <= '0;
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      wb_src  <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        count[i] <= 2'd0;
        for (int j = 0; j < 2; j++) begin
          addr_q[i][j] <= '0;
          data_q[i][j] <= '0;
        end
      end
    end else if (clk_en) begin
      for (int i = 0; i < N_SRC; i++) begin
        // Push while popping only happens at count 1 (ready is low at 2), so the new entry becomes head.
        if (pop_v[i] && push_v[i]) begin
          addr_q[i][0] <= src_addr[i*ADDR_W +: ADDR_W];
          data_q[i][0] <= src_data[i*DATA_W +: DATA_W];
        end else if (pop_v[i]) begin
          addr_q[i][0] <= addr_q[i][1];
          data_q[i][0] <= data_q[i][1];
          count[i]     <= count[i] - 2'd1;
        end else if (push_v[i]) begin
          if (count[i] == 2'd0) begin
            addr_q[i][0] <= src_addr[i*ADDR_W +: ADDR_W];
            data_q[i][0] <= src_data[i*DATA_W +: DATA_W];
          end else begin
            addr_q[i][1] <= src_addr[i*ADDR_W +: ADDR_W];
            data_q[i][1] <= src_data[i*DATA_W +: DATA_W];
          end
          count[i] <= count[i] + 2'd1;
        end
      end
      if (found) begin
        wb_en   <= (addr_q[winner][0] != '0);
        wb_addr <= addr_q[winner][0];
        wb_data <= data_q[winner][0];
        wb_src  <= winner;
        rr_ptr  <= (winner == LAST) ? '0 : winner + SRC_W'(1);
      end else begin
        wb_en <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter_m1.sv
// Directed bench for wb_arbiter_m1 (N_SRC=3, DATA_W=16, ADDR_W=4) with hand-computed expectations.
module tb_wb_arbiter_m1;
  logic        clk = 1'b0;
  logic        async_rst;
  logic        clk_en;
  logic [2:0]  src_valid;
  logic [11:0] src_addr;
  logic [47:0] src_data;
  logic [2:0]  src_ready;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [1:0]  wb_src;
  logic        idle;

  int checks   = 0;
  int failures = 0;

  wb_arbiter_m1 #(.N_SRC(3), .DATA_W(16), .ADDR_W(4)) dut (
    .clk(clk), .async_rst(async_rst), .clk_en(clk_en),
    .src_valid(src_valid), .src_addr(src_addr), .src_data(src_data),
    .src_ready(src_ready), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_src(wb_src), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [3:0] a, input logic [15:0] d);
    src_addr[s*4 +: 4]   = a;
    src_data[s*16 +: 16] = d;
  endtask

  task automatic do_reset();
    async_rst = 1'b1;
    src_valid = '0;
    clk_en    = 1'b1;
    #3;
    async_rst = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic en, input logic [3:0] a,
                         input logic [15:0] d, input logic [1:0] s);
    chk({tag, "_en"}, 32'(wb_en), 32'(en));
    if (en) begin
      chk({tag, "_addr"}, 32'(wb_addr), 32'(a));
      chk({tag, "_data"}, 32'(wb_data), 32'(d));
      chk({tag, "_src"},  32'(wb_src),  32'(s));
    end
  endtask

  int          n [3];
  logic [2:0]  rdy_pre;
  int          seen;
  int          exp_src  [12] = '{0, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 0};
  int          exp_addr [12] = '{0, 1, 5, 9, 2, 6, 10, 3, 7, 11, 4, 0};
  int          exp_data [12] = '{0, 'h1000, 'h2000, 'h3000, 'h1001, 'h2001, 'h3001,
                                 'h1002, 'h2002, 'h3002, 'h1003, 0};
  int          exp_rdy  [6]  = '{7, 1, 2, 4, 1, 2};
  int          bp_addr  [4]  = '{5, 6, 7, 8};

  initial begin
    async_rst = 1'b1;
    clk_en    = 1'b1;
    src_valid = '0;
    src_addr  = '0;
    src_data  = '0;
    #12;
    chk("rst_en",    32'(wb_en),     32'd0);
    chk("rst_addr",  32'(wb_addr),   32'd0);
    chk("rst_data",  32'(wb_data),   32'd0);
    chk("rst_src",   32'(wb_src),    32'd0);
    chk("rst_ready", 32'(src_ready), 32'd7);
    chk("rst_idle",  32'(idle),      32'd1);
    async_rst = 1'b0;

    // Single push from source 0
    set_src(0, 4'd3, 16'h1234);
    src_valid = 3'b001;
    tick();
    src_valid = '0;
    chk("single_c1_en",   32'(wb_en), 32'd0);
    chk("single_c1_idle", 32'(idle),  32'd0);
    tick();
    chk_out("single_c2", 1'b1, 4'd3, 16'h1234, 2'd0);
    chk("single_c2_idle", 32'(idle), 32'd0);
    tick();
    chk("single_c3_en",   32'(wb_en),   32'd0);
    chk("single_c3_idle", 32'(idle),    32'd1);
    chk("single_c3_hold", 32'(wb_addr), 32'd3);

    // Contention: all sources valid for 6 cycles, rr_ptr starts at 0
    do_reset();
    for (int s = 0; s < 3; s++) n[s] = 0;
    for (int k = 0; k < 12; k++) begin
      src_valid = (k < 6) ? 3'b111 : 3'b000;
      for (int s = 0; s < 3; s++) set_src(s, 4'(1 + 4*s + n[s]), 16'(16'h1000*(s+1) + n[s]));
      rdy_pre = src_ready;
      tick();
      for (int s = 0; s < 3; s++) if (src_valid[s] && rdy_pre[s]) n[s]++;
      chk_out($sformatf("cont%0d", k), (k >= 1 && k <= 10), 4'(exp_addr[k]),
              16'(exp_data[k]), 2'(exp_src[k]));
      if (k < 6) chk($sformatf("cont%0d_ready", k), 32'(src_ready), 32'(exp_rdy[k]));
    end
    src_valid = '0;
    chk("cont_n0",   32'(n[0]), 32'd4);
    chk("cont_n1",   32'(n[1]), 32'd3);
    chk("cont_n2",   32'(n[2]), 32'd3);
    chk("cont_idle", 32'(idle), 32'd1);

    // Backpressure: source 1 pushes 4 entries under contention
    do_reset();
    for (int s = 0; s < 3; s++) n[s] = 0;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      src_valid = {k < 7, n[1] < 4, k < 7};
      for (int s = 0; s < 3; s++) set_src(s, 4'(1 + 4*s + n[s]), 16'(16'h1000*(s+1) + n[s]));
      rdy_pre = src_ready;
      tick();
      for (int s = 0; s < 3; s++) if (src_valid[s] && rdy_pre[s]) n[s]++;
      if (k == 1) chk("bp_ready1_low", 32'(src_ready[1]), 32'd0);
      if (wb_en && wb_src == 2'd1) begin
        if (seen < 4) begin
          chk($sformatf("bp_addr%0d", seen), 32'(wb_addr), 32'(bp_addr[seen]));
          chk($sformatf("bp_data%0d", seen), 32'(wb_data), 32'h2000 + 32'(seen));
        end
        seen++;
      end
    end
    src_valid = '0;
    chk("bp_seen", 32'(seen), 32'd4);
    chk("bp_idle", 32'(idle), 32'd1);

    // r0 writes consume a slot but never assert wb_en
    do_reset();
    set_src(2, 4'd0, 16'hBEEF);
    src_valid = 3'b100;
    tick();
    set_src(2, 4'd5, 16'h0007);
    tick();
    src_valid = '0;
    chk("r0_c2_en",   32'(wb_en), 32'd0);
    chk("r0_c2_idle", 32'(idle),  32'd0);
    tick();
    chk_out("r0_c3", 1'b1, 4'd5, 16'h0007, 2'd2);
    tick();
    chk("r0_c4_en",   32'(wb_en), 32'd0);
    chk("r0_c4_idle", 32'(idle),  32'd1);

    // clk_en stall with two entries buffered
    do_reset();
    set_src(0, 4'd1, 16'h0A01);
    set_src(1, 4'd2, 16'h0A02);
    set_src(2, 4'd3, 16'h0A03);
    src_valid = 3'b111;
    tick();
    src_valid = '0;
    tick();
    chk_out("stall_pre", 1'b1, 4'd1, 16'h0A01, 2'd0);
    clk_en    = 1'b0;
    src_valid = 3'b111;
    for (int s = 0; s < 3; s++) set_src(s, 4'd14, 16'hFFFF);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out($sformatf("stall%0d", k), 1'b1, 4'd1, 16'h0A01, 2'd0);
      chk($sformatf("stall%0d_ready", k), 32'(src_ready), 32'd7);
      chk($sformatf("stall%0d_idle", k),  32'(idle),      32'd0);
    end
    clk_en    = 1'b1;
    src_valid = '0;
    tick();
    chk_out("resume1", 1'b1, 4'd2, 16'h0A02, 2'd1);
    tick();
    chk_out("resume2", 1'b1, 4'd3, 16'h0A03, 2'd2);
    tick();
    chk("resume3_en",   32'(wb_en), 32'd0);
    chk("resume3_idle", 32'(idle),  32'd1);

    // Async reset between edges flushes buffered entries
    do_reset();
    set_src(0, 4'd1, 16'h0B01);
    set_src(1, 4'd2, 16'h0B02);
    set_src(2, 4'd3, 16'h0B03);
    src_valid = 3'b111;
    tick();
    src_valid = '0;
    tick();
    chk("arst_pre_en", 32'(wb_en), 32'd1);
    #2;
    async_rst = 1'b1;
    #1;
    chk("arst_en",    32'(wb_en),     32'd0);
    chk("arst_addr",  32'(wb_addr),   32'd0);
    chk("arst_data",  32'(wb_data),   32'd0);
    chk("arst_src",   32'(wb_src),    32'd0);
    chk("arst_ready", 32'(src_ready), 32'd7);
    chk("arst_idle",  32'(idle),      32'd1);
    #2;
    async_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("post_rst%0d_en", k),   32'(wb_en), 32'd0);
      chk($sformatf("post_rst%0d_idle", k), 32'(idle),  32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_arbiter_m1.md
Name: wb_arbiter_m1

Overview:
Shares the single register-file write port (write_en / writeback_addr / data_in) between N_SRC writeback sources, e.g. ALU, load/store unit and mul/div. Each source has a 2-entry FIFO. A round-robin arbiter pops one entry per enabled cycle into a registered output stage that drives the regfile write port directly. Because the scoreboard clears on write, every accepted result must eventually be written. The block never drops valid entries, except writes to r0.

Parameters:
N_SRC, 3, number of writeback sources (2..8)
DATA_W, 16, result width
ADDR_W, 4, register address width

Ports:
clk  in  1  clock
async_rst  in  1  asynchronous active-high reset
clk_en  in  1  global clock enable; when low, no state changes
src_valid  in  N_SRC  per-source result valid
src_addr  in  N_SRC*ADDR_W  per-source destination register; source i occupies bits [i*ADDR_W +: ADDR_W]
src_data  in  N_SRC*DATA_W  per-source result; source i occupies bits [i*DATA_W +: DATA_W]
src_ready  out  N_SRC  FIFO i can accept an entry
wb_en  out  1  regfile write enable
wb_addr  out  ADDR_W  regfile write address
wb_data  out  DATA_W  regfile write data
wb_src  out  $clog2(N_SRC)  index of the source that produced the current write (debug/perf)
idle  out  1  all FIFOs empty and wb_en low

Behaviour:
- Reset (async, active-high):
  - All FIFO counts 0; rr_ptr = 0.
  - wb_en = 0, wb_addr = 0, wb_data = 0, wb_src = 0.
  - src_ready = all ones (derived from count); idle = 1.
- Gating: all state updates are qualified by clk_en. With clk_en = 0, FIFOs, rr_ptr and output registers hold. wb_en holds its value; the regfile gates on the same clk_en, so no duplicate write occurs.
- src_ready[i] = (count[i] < 2). It is a pure function of state, with no combinational path from any src_valid.
- Accept: src_valid[i] && src_ready[i] && clk_en pushes {addr, data} into FIFO i. FIFO i is in-order.
- Pop and grant, per enabled cycle:
  - Candidate set = FIFOs with count > 0.
  - Winner = first candidate scanning i = rr_ptr, rr_ptr+1, … mod N_SRC.
  - The winner's head is popped. rr_ptr <= (winner+1) mod N_SRC. With no candidates, rr_ptr holds.
- Simultaneous push and pop on the same FIFO in one cycle is legal; the count is unchanged. A FIFO with count 2 that is popped still shows src_ready = 0 that cycle, because ready is registered state. Its count becomes 1 next cycle.
- Output stage: on the cycle after a pop, the output registers are loaded.
  - wb_en = (popped addr != 0); wb_addr and wb_data are the popped values; wb_src = winner.
  - With no pop, wb_en <= 0; wb_addr, wb_data and wb_src hold.
  - Latency from input handshake to wb_en is 2 enabled cycles minimum (push, then pop/register). wb_en is therefore asserted in the 2nd enabled cycle after the handshake.
- r0 writes are popped and consume an arbitration slot but never assert wb_en.
- Throughput: one write per enabled cycle aggregate. Each source sustains 1/cycle when it is the only active source.
- Fairness: under continuous contention, each source is granted at least once every N_SRC pops.
- Ordering: preserved within a source. Across sources, ordering is not guaranteed. Issue logic guarantees at most one outstanding write per register, so the arbiter performs no address hazard checks.
- idle = (all count == 0) && !wb_en.
- Reset mid-operation flushes buffered entries; the regfile scoreboard is reset by the same event.

Test Plan:
- Reset, then a single ALU push: src0 addr=3 data=16'h1234 at cycle 0 → wb_en=1, wb_addr=3, wb_data=16'h1234, wb_src=0 at cycle 2. idle returns to 1 at cycle 3.
- Contention: all 3 sources push every cycle with distinct addrs for 6 cycles, starting from rr_ptr=0 → wb_src sequence is 0,1,2,0,1,2…, with no loss. No source's src_ready is low for more than 2 consecutive cycles.
- Backpressure: src1 pushes 4 entries back-to-back while src0 and src2 also push continuously → src_ready[1] drops after 2 unpopped entries. All 4 of src1's entries appear on the write port in push order.
- r0 drop: src2 pushes addr=0 data=16'hBEEF, then addr=5 data=16'h0007 → no wb_en for the first entry; wb_en=1, addr=5, data=7 one cycle later.
- clk_en stall: hold clk_en=0 for 3 cycles with 2 entries buffered and src_valid asserted → no state change and no new pushes. Resume produces exactly 2 writes, with no duplicates.
- Async reset asserted mid-stream, between clock edges → outputs go to 0 immediately and src_ready becomes all ones. No write occurs from pre-reset entries after release.
